// File: rtl/sdram_arbiter.sv
// Owns the SDRAM function module call/done interface: INIT after reset, periodic
// REFRESH, and round-robin READ/WRITE service for two bus masters.
module sdram_arbiter #(
  parameter logic [15:0] REFRESH_CYCLES = 16'd1500,
  parameter int          ADDR_W         = 25
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              m0_req_i,
  input  logic              m0_we_i,
  input  logic [3:0]        m0_sel_i,
  input  logic [ADDR_W-1:0] m0_addr_i,
  input  logic [31:0]       m0_data_i,
  output logic [31:0]       m0_data_o,
  output logic              m0_ack_o,
  input  logic              m1_req_i,
  input  logic              m1_we_i,
  input  logic [3:0]        m1_sel_i,
  input  logic [ADDR_W-1:0] m1_addr_i,
  input  logic [31:0]       m1_data_i,
  output logic [31:0]       m1_data_o,
  output logic              m1_ack_o,
  output logic [3:0]        call_o,
  input  logic              done_i,
  output logic [3:0]        sel_o,
  output logic [ADDR_W-1:0] addr_o,
  output logic [31:0]       wdata_o,
  input  logic [31:0]       rdata_i,
  output logic              ready_o
);

  localparam logic [2:0] S_INIT = 3'd0;
  localparam logic [2:0] S_IDLE = 3'd1;
  localparam logic [2:0] S_REF  = 3'd2;
  localparam logic [2:0] S_ACC  = 3'd3;
  localparam logic [2:0] S_GAP  = 3'd4;

  localparam logic [3:0] CALL_NONE    = 4'b0000;
  localparam logic [3:0] CALL_INIT    = 4'b0001;
  localparam logic [3:0] CALL_REFRESH = 4'b0010;
  localparam logic [3:0] CALL_READ    = 4'b0100;
  localparam logic [3:0] CALL_WRITE   = 4'b1000;

  logic [2:0]  state_reg;
  logic [15:0] ref_cnt_reg;
  logic        ref_pending_reg;
  logic        last_grant_reg;   // 0 = m0, 1 = m1
  logic        owner_reg;        // master owning the access in flight
  logic        req_any;
  logic        grant_m1;
  logic        ref_issue;
  logic        ref_expire;

  assign req_any    = m0_req_i | m1_req_i;
  assign grant_m1   = (m0_req_i && m1_req_i) ? ~last_grant_reg : m1_req_i;
  assign ref_issue  = (state_reg == S_IDLE) && ref_pending_reg;
  assign ref_expire = ready_o && (ref_cnt_reg == REFRESH_CYCLES - 16'd1);

  // Pending flag is sticky; a clear on issue takes precedence over a coincident expiry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ref_cnt_reg     <= 16'd0;
      ref_pending_reg <= 1'b0;
    end else begin
      if (!ready_o || ref_expire) begin
        ref_cnt_reg <= 16'd0;
      end else begin
        ref_cnt_reg <= ref_cnt_reg + 16'd1;
      end

      if (ref_issue) begin
        ref_pending_reg <= 1'b0;
      end else if (ref_expire) begin
        ref_pending_reg <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= S_INIT;
      call_o         <= CALL_NONE;
      sel_o          <= 4'h0;
      addr_o         <= '0;
      wdata_o        <= 32'h0;
      m0_ack_o       <= 1'b0;
      m1_ack_o       <= 1'b0;
      m0_data_o      <= 32'h0;
      m1_data_o      <= 32'h0;
      ready_o        <= 1'b0;
      last_grant_reg <= 1'b1;
      owner_reg      <= 1'b0;
    end else begin
      m0_ack_o <= 1'b0;
      m1_ack_o <= 1'b0;

      case (state_reg)
        S_INIT: begin
          if (call_o == CALL_NONE) begin
            call_o <= CALL_INIT;
          end else if (done_i) begin
            call_o    <= CALL_NONE;
            ready_o   <= 1'b1;
            state_reg <= S_GAP;
          end
        end

        S_IDLE: begin
          if (ref_pending_reg) begin
            call_o    <= CALL_REFRESH;
            sel_o     <= 4'h0;
            state_reg <= S_REF;
          end else if (req_any) begin
            owner_reg      <= grant_m1;
            last_grant_reg <= grant_m1;
            state_reg      <= S_ACC;
            if (grant_m1) begin
              sel_o   <= m1_sel_i;
              addr_o  <= m1_addr_i;
              wdata_o <= m1_data_i;
              call_o  <= m1_we_i ? CALL_WRITE : CALL_READ;
            end else begin
              sel_o   <= m0_sel_i;
              addr_o  <= m0_addr_i;
              wdata_o <= m0_data_i;
              call_o  <= m0_we_i ? CALL_WRITE : CALL_READ;
            end
          end
        end

        S_REF: begin
          if (done_i) begin
            call_o    <= CALL_NONE;
            state_reg <= S_GAP;
          end
        end

        S_ACC: begin
          if (done_i) begin
            call_o    <= CALL_NONE;
            state_reg <= S_GAP;
            if (owner_reg) begin
              m1_ack_o <= 1'b1;
              if (call_o == CALL_READ) m1_data_o <= rdata_i;
            end else begin
              m0_ack_o <= 1'b1;
              if (call_o == CALL_READ) m0_data_o <= rdata_i;
            end
          end
        end

        S_GAP: begin
          state_reg <= S_IDLE;
        end

        default: begin
          call_o    <= CALL_NONE;
          state_reg <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sdram_arbiter.sv
// Directed bench for sdram_arbiter with a behavioural function-module stub that
// answers each call after a programmable latency.
module tb_sdram_arbiter;
  localparam int ADDR_W = 25;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              m0_req_i = 1'b0, m0_we_i = 1'b0;
  logic [3:0]        m0_sel_i = 4'h0;
  logic [ADDR_W-1:0] m0_addr_i = '0;
  logic [31:0]       m0_data_i = 32'h0;
  logic [31:0]       m0_data_o;
  logic              m0_ack_o;
  logic              m1_req_i = 1'b0, m1_we_i = 1'b0;
  logic [3:0]        m1_sel_i = 4'h0;
  logic [ADDR_W-1:0] m1_addr_i = '0;
  logic [31:0]       m1_data_i = 32'h0;
  logic [31:0]       m1_data_o;
  logic              m1_ack_o;
  logic [3:0]        call_o;
  logic              done_i = 1'b0;
  logic [3:0]        sel_o;
  logic [ADDR_W-1:0] addr_o;
  logic [31:0]       wdata_o;
  logic [31:0]       rdata_i = 32'h0;
  logic              ready_o;

  sdram_arbiter #(.REFRESH_CYCLES(16'd200), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .m0_req_i(m0_req_i), .m0_we_i(m0_we_i), .m0_sel_i(m0_sel_i), .m0_addr_i(m0_addr_i),
    .m0_data_i(m0_data_i), .m0_data_o(m0_data_o), .m0_ack_o(m0_ack_o),
    .m1_req_i(m1_req_i), .m1_we_i(m1_we_i), .m1_sel_i(m1_sel_i), .m1_addr_i(m1_addr_i),
    .m1_data_i(m1_data_i), .m1_data_o(m1_data_o), .m1_ack_o(m1_ack_o),
    .call_o(call_o), .done_i(done_i), .sel_o(sel_o), .addr_o(addr_o),
    .wdata_o(wdata_o), .rdata_i(rdata_i), .ready_o(ready_o)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_fail = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Function-module stub state and call log
  int                stub_lat = 40;
  int                stub_cnt = 0;
  bit                stub_busy = 1'b0;
  logic [3:0]        stub_call = 4'h0;
  logic [ADDR_W-1:0] cap_addr = '0;
  logic [31:0]       cap_wdata = 32'h0;
  logic [3:0]        cap_sel = 4'h0;
  logic [3:0]        last_call = 4'h0;
  logic [ADDR_W-1:0] last_addr = '0;
  int                drift = 0;
  int                ref_cnt = 0;
  int                ref_last = 0;
  int                ref_prev = 0;
  int                ref_sel_bad = 0;
  logic [31:0]       rd_q[$];

  always @(negedge clk) begin
    if (!rst_n) begin
      done_i    = 1'b0;
      stub_busy = 1'b0;
    end else if (done_i) begin
      done_i = 1'b0;
    end else if (stub_busy) begin
      if (call_o !== stub_call || addr_o !== cap_addr || wdata_o !== cap_wdata || sel_o !== cap_sel)
        drift++;
      if (stub_cnt <= 1) begin
        if (stub_call == 4'b0100) begin
          if (rd_q.size() > 0) rdata_i = rd_q.pop_front();
          else rdata_i = 32'hCAFE0000 ^ 32'(cyc);
        end
        done_i    = 1'b1;
        stub_busy = 1'b0;
        $display("[%0d] call=%b addr=%h wdata=%h sel=%h rdata=%h",
                 cyc, stub_call, cap_addr, cap_wdata, cap_sel, rdata_i);
      end else begin
        stub_cnt--;
      end
    end else if (call_o != 4'h0) begin
      stub_busy = 1'b1;
      stub_cnt  = stub_lat;
      stub_call = call_o;
      cap_addr  = addr_o;
      cap_wdata = wdata_o;
      cap_sel   = sel_o;
      last_call = call_o;
      last_addr = addr_o;
      if (call_o == 4'b0010) begin
        ref_cnt++;
        ref_prev = ref_last;
        ref_last = cyc;
        if (sel_o != 4'h0) ref_sel_bad++;
      end
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic wait_ack(input int m, input int budget, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < budget; i++) begin
      step();
      if ((m == 0 && m0_ack_o) || (m == 1 && m1_ack_o)) begin
        seen = 1'b1;
        break;
      end
    end
  endtask

  initial begin
    bit seen;
    int bad;
    int acks;
    int r0;

    // Reset values
    repeat (3) step();
    chk("rst_call", 32'(call_o), 32'h0);
    chk("rst_ready", 32'(ready_o), 32'h0);
    chk("rst_acks", 32'({m0_ack_o, m1_ack_o}), 32'h0);
    chk("rst_m0_data", m0_data_o, 32'h0);
    chk("rst_m1_data", m1_data_o, 32'h0);
    chk("rst_fields", 32'({sel_o, wdata_o != 32'h0, addr_o != '0}), 32'h0);

    // INIT: call held through the done cycle, m0 ignored until ready
    stub_lat = 40;
    rst_n = 1'b1;
    m0_we_i = 1'b0; m0_addr_i = 25'h0000042; m0_sel_i = 4'hF; m0_req_i = 1'b1;
    step();
    chk("init_first_call", 32'(call_o), 32'h1);
    seen = 1'b0; bad = 0;
    for (int i = 0; i < 100; i++) begin
      step();
      if (call_o != 4'h0 && call_o != 4'h1) bad++;
      if (m0_ack_o) bad++;
      if (done_i) begin seen = 1'b1; break; end
    end
    chk("init_done_seen", 32'(seen), 32'h1);
    chk("init_call_in_done", 32'(call_o), 32'h1);
    chk("init_ready_in_done", 32'(ready_o), 32'h0);
    chk("init_no_grant", 32'(bad), 32'h0);
    step();
    chk("init_call_after", 32'(call_o), 32'h0);
    chk("init_ready_after", 32'(ready_o), 32'h1);
    m0_req_i = 1'b0;
    step();
    chk("init_ready_stays", 32'(ready_o), 32'h1);
    chk("init_idle_call", 32'(call_o), 32'h0);

    // m1 write
    stub_lat = 5; drift = 0;
    m1_we_i = 1'b1; m1_sel_i = 4'hF; m1_addr_i = 25'h0001234; m1_data_i = 32'hDEADBEEF;
    m1_req_i = 1'b1;
    wait_ack(1, 50, seen);
    chk("wr_ack_seen", 32'(seen), 32'h1);
    chk("wr_call", 32'(last_call), 32'h8);
    chk("wr_addr", 32'(cap_addr), 32'h0001234);
    chk("wr_wdata", cap_wdata, 32'hDEADBEEF);
    chk("wr_sel", 32'(cap_sel), 32'hF);
    chk("wr_m0_ack", 32'(m0_ack_o), 32'h0);
    chk("wr_gap_call", 32'(call_o), 32'h0);
    m1_req_i = 1'b0;
    step();
    chk("wr_ack_pulse", 32'(m1_ack_o), 32'h0);
    chk("wr_idle_call", 32'(call_o), 32'h0);
    chk("wr_stable", 32'(drift), 32'h0);

    // Simultaneous reads: m0 first, then m1
    rd_q.push_back(32'h11111111);
    rd_q.push_back(32'h22222222);
    m0_we_i = 1'b0; m0_sel_i = 4'h3; m0_addr_i = 25'h0000100; m0_req_i = 1'b1;
    m1_we_i = 1'b0; m1_sel_i = 4'hC; m1_addr_i = 25'h0000200; m1_req_i = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 50; i++) begin
      step();
      if (m0_ack_o || m1_ack_o) begin seen = 1'b1; break; end
    end
    chk("rr_first_seen", 32'(seen), 32'h1);
    chk("rr_first_m0_ack", 32'(m0_ack_o), 32'h1);
    chk("rr_first_m1_ack", 32'(m1_ack_o), 32'h0);
    chk("rr_m0_data", m0_data_o, 32'h11111111);
    chk("rr_m0_addr", 32'(last_addr), 32'h100);
    m0_req_i = 1'b0;
    seen = 1'b0; acks = 0;
    for (int i = 0; i < 50; i++) begin
      step();
      if (m0_ack_o) acks++;
      if (m1_ack_o) begin seen = 1'b1; break; end
    end
    chk("rr_second_seen", 32'(seen), 32'h1);
    chk("rr_m1_data", m1_data_o, 32'h22222222);
    chk("rr_m0_data_held", m0_data_o, 32'h11111111);
    chk("rr_m1_addr", 32'(last_addr), 32'h200);
    chk("rr_m0_single_ack", 32'(acks), 32'h0);
    m1_req_i = 1'b0;
    step();
    chk("rr_m1_ack_pulse", 32'(m1_ack_o), 32'h0);

    // Periodic refresh against a continuously requesting m0
    stub_lat = 3; r0 = ref_cnt; acks = 0;
    m0_we_i = 1'b0; m0_addr_i = 25'h0000300; m0_req_i = 1'b1;
    for (int i = 0; i < 480; i++) begin
      step();
      if (m0_ack_o) acks++;
    end
    chk("ref_count_ge2", 32'(ref_cnt - r0 >= 2), 32'h1);
    chk("ref_interval", 32'((ref_last - ref_prev) >= 190 && (ref_last - ref_prev) <= 210), 32'h1);
    chk("ref_sel_zero", 32'(ref_sel_bad), 32'h0);
    chk("ref_reads_continue", 32'(acks > 20), 32'h1);
    r0 = ref_cnt; seen = 1'b0;
    for (int i = 0; i < 300; i++) begin
      step();
      if (ref_cnt > r0) begin seen = 1'b1; break; end
    end
    chk("ref_next_seen", 32'(seen), 32'h1);
    wait_ack(0, 50, seen);
    chk("ref_then_read", 32'(seen), 32'h1);
    m0_req_i = 1'b0;

    // 450-cycle access spans two expiries: exactly one refresh afterwards
    r0 = ref_cnt; drift = 0;
    stub_lat = 450;
    m0_we_i = 1'b1; m0_sel_i = 4'hF; m0_addr_i = 25'h0000400; m0_data_i = 32'h12345678;
    m0_req_i = 1'b1;
    wait_ack(0, 600, seen);
    chk("long_ack_seen", 32'(seen), 32'h1);
    chk("long_call", 32'(last_call), 32'h8);
    chk("long_no_ref_during", 32'(ref_cnt - r0), 32'h0);
    chk("long_stable", 32'(drift), 32'h0);
    stub_lat = 3;
    m0_we_i = 1'b0;
    wait_ack(0, 60, seen);
    chk("long_next_ack", 32'(seen), 32'h1);
    chk("long_one_refresh", 32'(ref_cnt - r0), 32'h1);
    chk("long_next_is_read", 32'(last_call), 32'h4);
    m0_req_i = 1'b0;

    // Reset in the middle of a read
    stub_lat = 20;
    m0_we_i = 1'b0; m0_addr_i = 25'h0000500; m0_req_i = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 30; i++) begin
      step();
      if (call_o == 4'b0100) begin seen = 1'b1; break; end
    end
    chk("mid_read_started", 32'(seen), 32'h1);
    repeat (3) step();
    rst_n = 1'b0;
    #1;
    chk("mid_rst_call", 32'(call_o), 32'h0);
    chk("mid_rst_ready", 32'(ready_o), 32'h0);
    chk("mid_rst_m0_data", m0_data_o, 32'h0);
    m0_req_i = 1'b0;
    stub_lat = 5;
    acks = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      if (m0_ack_o || m1_ack_o) acks++;
    end
    chk("mid_rst_no_ack", 32'(acks), 32'h0);
    rst_n = 1'b1;
    step();
    chk("mid_reinit_call", 32'(call_o), 32'h1);
    seen = 1'b0;
    for (int i = 0; i < 30; i++) begin
      step();
      if (ready_o) begin seen = 1'b1; break; end
    end
    chk("mid_reinit_ready", 32'(seen), 32'h1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
